// File: rtl/qubit_measure_unit_pkg.sv
// qubit_measure_unit_pkg
//   Shared fixed-point constants, stage-1 payload type and the complex
//   magnitude-squared helper for the qubit readout pipeline.
//   Amplitudes are signed S3.4; probabilities are unsigned Q.8.
package qubit_measure_unit_pkg;

  localparam int TOTAL_WIDTH = 8;
  localparam int FRAC_WIDTH  = 4;
  localparam int ADD_WIDTH   = TOTAL_WIDTH + 1;

  // 1.0 in S3.4
  localparam int ONE_FXP     = 1 << FRAC_WIDTH;

  // |re|^2 + |im|^2 at full precision: max 2*128^2 = 32768 fits in 17 bits
  localparam int PROB_WIDTH  = 2 * TOTAL_WIDTH + 1;
  // pa + pb
  localparam int TOT_WIDTH   = PROB_WIDTH + 1;

  localparam int LFSR_WIDTH  = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

  // random fraction r = lfsr[7:0], unsigned Q0.8
  localparam int RAND_WIDTH  = 8;

  typedef struct packed {
    logic [PROB_WIDTH-1:0] pa;
    logic [PROB_WIDTH-1:0] pb;
    logic [RAND_WIDTH-1:0] r;
  } s1_t;

  // Squares are taken on sign-extended operands so the 16-bit product is
  // exact (-128 * -128 = 16384 still fits as a positive value).
  function automatic logic [PROB_WIDTH-1:0] mag_sq(
    input logic signed [TOTAL_WIDTH-1:0] re,
    input logic signed [TOTAL_WIDTH-1:0] im
  );
    logic signed [2*TOTAL_WIDTH-1:0] re_x;
    logic signed [2*TOTAL_WIDTH-1:0] im_x;
    logic signed [2*TOTAL_WIDTH-1:0] re_sq;
    logic signed [2*TOTAL_WIDTH-1:0] im_sq;
    re_x  = (2*TOTAL_WIDTH)'(re);
    im_x  = (2*TOTAL_WIDTH)'(im);
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    return {1'b0, re_sq} + {1'b0, im_sq};
  endfunction

endpackage

// File: rtl/qubit_measure_unit_lfsr16_galois.sv
// lfsr16_galois
//   16-bit right-shifting Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
//   Ports:
//     clk, rst_n  : clock, synchronous active-low reset (state <- SEED)
//     advance     : step the register one position
//     load        : load seed_in (SEED when seed_in is zero); wins over advance
//     seed_in     : new seed
//     q           : current register value
module lfsr16_galois
  import qubit_measure_unit_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  output logic [LFSR_WIDTH-1:0] q
);

  logic [LFSR_WIDTH-1:0] lfsr_d;
  logic [LFSR_WIDTH-1:0] lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      // an all-zero state would lock the register, so fall back to SEED
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end else if (advance) begin
      lfsr_d = {1'b0, lfsr_q[LFSR_WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/qubit_measure_unit.sv
// qubit_measure_unit
//   Readout stage of the single-qubit pipeline. Takes (alpha, beta) in S3.4,
//   computes |alpha|^2 and |beta|^2, compares a random threshold against
//   |beta|^2 and emits the measured bit with the collapsed basis state.
//   Three-cycle fixed latency, one sample per clock, no backpressure.
//   Ports:
//     clk, rst_n                 : clock, synchronous active-low reset
//     valid_in                   : amplitudes valid this cycle
//     alpha_r/i, beta_r/i        : input amplitudes, signed S3.4
//     seed_load, seed_in         : LFSR reseed (pre-load value used this cycle)
//     stats_clr                  : zero both statistics counters
//     valid_out, meas_bit        : result strobe and measured outcome
//     coll_alpha_r/i, coll_beta_r/i : collapsed state, S3.4
//     zero_norm                  : input norm was zero, outcome forced to 0
//     sample_count, ones_count   : saturating outcome statistics
module qubit_measure_unit
  import qubit_measure_unit_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED      = 16'hACE1,
  parameter int                    CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_in,
  input  logic signed [TOTAL_WIDTH-1:0] alpha_r,
  input  logic signed [TOTAL_WIDTH-1:0] alpha_i,
  input  logic signed [TOTAL_WIDTH-1:0] beta_r,
  input  logic signed [TOTAL_WIDTH-1:0] beta_i,
  input  logic                          seed_load,
  input  logic [LFSR_WIDTH-1:0]         seed_in,
  input  logic                          stats_clr,
  output logic                          valid_out,
  output logic                          meas_bit,
  output logic signed [TOTAL_WIDTH-1:0] coll_alpha_r,
  output logic signed [TOTAL_WIDTH-1:0] coll_alpha_i,
  output logic signed [TOTAL_WIDTH-1:0] coll_beta_r,
  output logic signed [TOTAL_WIDTH-1:0] coll_beta_i,
  output logic                          zero_norm,
  output logic [CNT_WIDTH-1:0]          sample_count,
  output logic [CNT_WIDTH-1:0]          ones_count
);

  localparam int SCALE_WIDTH = TOT_WIDTH + RAND_WIDTH;
  localparam logic signed [TOTAL_WIDTH-1:0] ONE = TOTAL_WIDTH'(ONE_FXP);

  // ---------------------------------------------------------------- LFSR
  logic [LFSR_WIDTH-1:0] lfsr_val;
  logic                  unused_lfsr_hi;

  lfsr16_galois #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (valid_in),
    .load    (seed_load),
    .seed_in (seed_in),
    .q       (lfsr_val)
  );

  // only the low byte feeds the threshold
  assign unused_lfsr_hi = ^lfsr_val[LFSR_WIDTH-1:RAND_WIDTH];

  // ---------------------------------------------------------------- S1
  s1_t  s1_d;
  s1_t  s1_q;
  logic s1_valid_q;

  always_comb begin
    s1_d.pa = mag_sq(alpha_r, alpha_i);
    s1_d.pb = mag_sq(beta_r, beta_i);
    s1_d.r  = lfsr_val[RAND_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= valid_in;
      if (valid_in) begin
        s1_q <= s1_d;
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic [TOT_WIDTH-1:0]   tot_d;
  logic [TOT_WIDTH-1:0]   thr_d;
  logic [SCALE_WIDTH-1:0] scaled;
  logic [TOT_WIDTH-1:0]   tot_q;
  logic [TOT_WIDTH-1:0]   thr_q;
  logic [PROB_WIDTH-1:0]  pb_s2_q;
  logic                   s2_valid_q;

  always_comb begin
    tot_d  = TOT_WIDTH'(s1_q.pa) + TOT_WIDTH'(s1_q.pb);
    scaled = SCALE_WIDTH'(tot_d) * SCALE_WIDTH'(s1_q.r);
    // thr = tot * r / 256, truncated
    thr_d  = scaled[SCALE_WIDTH-1:RAND_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      tot_q      <= '0;
      thr_q      <= '0;
      pb_s2_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        tot_q   <= tot_d;
        thr_q   <= thr_d;
        pb_s2_q <= s1_q.pb;
      end
    end
  end

  // ---------------------------------------------------------------- S3
  logic                          zero_d;
  logic                          meas_d;
  logic signed [TOTAL_WIDTH-1:0] coll_ar_d;
  logic signed [TOTAL_WIDTH-1:0] coll_br_d;

  logic                          valid_out_q;
  logic                          meas_q;
  logic                          zero_norm_q;
  logic signed [TOTAL_WIDTH-1:0] coll_ar_q;
  logic signed [TOTAL_WIDTH-1:0] coll_ai_q;
  logic signed [TOTAL_WIDTH-1:0] coll_br_q;
  logic signed [TOTAL_WIDTH-1:0] coll_bi_q;

  always_comb begin
    zero_d    = (tot_q == '0);
    // P(1) = pb / tot: outcome is 1 when the scaled random point lands below pb
    meas_d    = !zero_d && (thr_q < TOT_WIDTH'(pb_s2_q));
    coll_ar_d = meas_d ? '0 : ONE;
    coll_br_d = meas_d ? ONE : '0;
  end

  // imaginary parts of the collapsed state are always zero (global phase
  // dropped) but stay registered so reset and hold behaviour is uniform
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out_q <= 1'b0;
      meas_q      <= 1'b0;
      zero_norm_q <= 1'b0;
      coll_ar_q   <= '0;
      coll_ai_q   <= '0;
      coll_br_q   <= '0;
      coll_bi_q   <= '0;
    end else begin
      valid_out_q <= s2_valid_q;
      if (s2_valid_q) begin
        meas_q      <= meas_d;
        zero_norm_q <= zero_d;
        coll_ar_q   <= coll_ar_d;
        coll_ai_q   <= '0;
        coll_br_q   <= coll_br_d;
        coll_bi_q   <= '0;
      end
    end
  end

  // ---------------------------------------------------------------- stats
  logic [CNT_WIDTH-1:0] sample_cnt_d;
  logic [CNT_WIDTH-1:0] ones_cnt_d;
  logic [CNT_WIDTH-1:0] sample_cnt_q;
  logic [CNT_WIDTH-1:0] ones_cnt_q;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    if (stats_clr) begin
      sample_cnt_d = '0;
      ones_cnt_d   = '0;
    end else if (valid_out_q) begin
      if (sample_cnt_q != '1) begin
        sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
      end
      if (meas_q && (ones_cnt_q != '1)) begin
        ones_cnt_d = ones_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt_q <= '0;
      ones_cnt_q   <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
    end
  end

  assign valid_out    = valid_out_q;
  assign meas_bit     = meas_q;
  assign zero_norm    = zero_norm_q;
  assign coll_alpha_r = coll_ar_q;
  assign coll_alpha_i = coll_ai_q;
  assign coll_beta_r  = coll_br_q;
  assign coll_beta_i  = coll_bi_q;
  assign sample_count = sample_cnt_q;
  assign ones_count   = ones_cnt_q;

endmodule

// File: tb/tb_qubit_measure_unit.sv
module tb_qubit_measure_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic              valid_in = 1'b0;
  logic signed [7:0] alpha_r = '0;
  logic signed [7:0] alpha_i = '0;
  logic signed [7:0] beta_r = '0;
  logic signed [7:0] beta_i = '0;
  logic              seed_load = 1'b0;
  logic [15:0]       seed_in = '0;
  logic              stats_clr = 1'b0;

  logic              valid_out;
  logic              meas_bit;
  logic signed [7:0] coll_alpha_r;
  logic signed [7:0] coll_alpha_i;
  logic signed [7:0] coll_beta_r;
  logic signed [7:0] coll_beta_i;
  logic              zero_norm;
  logic [15:0]       sample_count;
  logic [15:0]       ones_count;

  qubit_measure_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .alpha_r      (alpha_r),
    .alpha_i      (alpha_i),
    .beta_r       (beta_r),
    .beta_i       (beta_i),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .stats_clr    (stats_clr),
    .valid_out    (valid_out),
    .meas_bit     (meas_bit),
    .coll_alpha_r (coll_alpha_r),
    .coll_alpha_i (coll_alpha_i),
    .coll_beta_r  (coll_beta_r),
    .coll_beta_i  (coll_beta_i),
    .zero_norm    (zero_norm),
    .sample_count (sample_count),
    .ones_count   (ones_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- reference model
  logic [15:0] m_lfsr = 16'hACE1;
  logic p1v = 0, p1m = 0, p1z = 0;
  logic p2v = 0, p2m = 0, p2z = 0;
  logic m_vout = 0, m_meas = 0, m_zn = 0, m_has = 0;
  int   m_samp = 0, m_ones = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // returns {zero_norm, meas}
  function automatic logic [1:0] ref_meas(input int ar, input int ai,
                                          input int br, input int bi,
                                          input int r);
    int pa, pb, tot, thr;
    pa  = ar*ar + ai*ai;
    pb  = br*br + bi*bi;
    tot = pa + pb;
    thr = (tot * r) / 256;
    if (tot == 0) return 2'b10;
    return {1'b0, (thr < pb)};
  endfunction

  task automatic tick();
    logic [1:0] res;
    @(posedge clk);
    if (!rst_n) begin
      p1v = 0; p2v = 0; m_vout = 0; m_meas = 0; m_zn = 0; m_has = 0;
      m_samp = 0; m_ones = 0; m_lfsr = 16'hACE1;
    end else begin
      if (stats_clr) begin
        m_samp = 0; m_ones = 0;
      end else if (m_vout) begin
        if (m_samp < 65535) m_samp++;
        if (m_meas && m_ones < 65535) m_ones++;
      end
      m_vout = p2v;
      if (p2v) begin m_meas = p2m; m_zn = p2z; m_has = 1; end
      p2v = p1v; p2m = p1m; p2z = p1z;
      p1v = valid_in;
      if (valid_in) begin
        res = ref_meas(int'(alpha_r), int'(alpha_i), int'(beta_r), int'(beta_i),
                       int'(m_lfsr[7:0]));
        p1z = res[1]; p1m = res[0];
      end
      if (seed_load) m_lfsr = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
      else if (valid_in) m_lfsr = lfsr_next(m_lfsr);
    end
    #1;
    chk("valid_out", int'(valid_out), int'(m_vout));
    chk("meas_bit", int'(meas_bit), int'(m_meas));
    chk("zero_norm", int'(zero_norm), int'(m_zn));
    chk("coll_alpha_r", int'(coll_alpha_r), (m_has && !m_meas) ? 16 : 0);
    chk("coll_alpha_i", int'(coll_alpha_i), 0);
    chk("coll_beta_r", int'(coll_beta_r), (m_has && m_meas) ? 16 : 0);
    chk("coll_beta_i", int'(coll_beta_i), 0);
    chk("sample_count", int'(sample_count), m_samp);
    chk("ones_count", int'(ones_count), m_ones);
  endtask

  task automatic set_amp(input int ar, input int ai, input int br, input int bi);
    alpha_r = 8'(ar); alpha_i = 8'(ai); beta_r = 8'(br); beta_i = 8'(bi);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int ones_snap;

  initial begin
    // reset
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    idle(3);
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_sample_count", int'(sample_count), 0);
    chk("rst_coll_alpha_r", int'(coll_alpha_r), 0);

    // deterministic |0>
    set_amp(16, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'b1;
      tick();
      if (i < 2) chk("lat_low", int'(valid_out), 0);
      if (i == 2) chk("lat_high", int'(valid_out), 1);
    end
    idle(5);
    chk("s0_samples", int'(sample_count), 20);
    chk("s0_ones", int'(ones_count), 0);
    chk("s0_coll_alpha_r", int'(coll_alpha_r), 16);
    chk("s0_meas", int'(meas_bit), 0);

    // deterministic |1>, beta = -1.0i
    set_amp(0, 0, 0, -16);
    valid_in = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    idle(5);
    chk("s1_meas", int'(meas_bit), 1);
    chk("s1_coll_beta_r", int'(coll_beta_r), 16);
    chk("s1_coll_beta_i", int'(coll_beta_i), 0);
    chk("s1_ones", int'(ones_count), 10);
    chk("s1_samples", int'(sample_count), 30);

    // zero norm
    set_amp(0, 0, 0, 0);
    valid_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    idle(5);
    chk("zn_flag", int'(zero_norm), 1);
    chk("zn_meas", int'(meas_bit), 0);
    chk("zn_coll_alpha_r", int'(coll_alpha_r), 16);
    chk("zn_samples", int'(sample_count), 35);
    chk("zn_ones", int'(ones_count), 10);

    // superposition, seed 0x0001 loaded on an idle cycle
    stats_clr = 1'b1; seed_load = 1'b1; seed_in = 16'h0001;
    tick();
    stats_clr = 1'b0; seed_load = 1'b0;
    set_amp(11, 0, 11, 0);
    valid_in = 1'b1;
    for (int i = 0; i < 1000; i++) tick();
    idle(5);
    chk("sup1_samples", int'(sample_count), 1000);
    ones_snap = int'(ones_count);
    chk("sup1_ones_range", int'(ones_snap >= 450 && ones_snap <= 550), 1);

    // seed 0 falls back to SEED; load on a valid cycle (pre-load value used)
    stats_clr = 1'b1; seed_load = 1'b1; seed_in = 16'h0000; valid_in = 1'b1;
    tick();
    stats_clr = 1'b0; seed_load = 1'b0;
    for (int i = 0; i < 999; i++) tick();
    idle(5);
    chk("sup0_samples", int'(sample_count), 1000);
    ones_snap = int'(ones_count);
    chk("sup0_ones_range", int'(ones_snap >= 450 && ones_snap <= 550), 1);

    // reset with three samples in flight
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    valid_in = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("flush_no_valid", int'(valid_out), 0);
    end
    chk("flush_samples", int'(sample_count), 0);
    valid_in = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    idle(5);
    chk("post_rst_samples", int'(sample_count), 8);

    // clear on the same cycle as a valid_out
    valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        chk("clr_vout_high", int'(valid_out), 1);
        stats_clr = 1'b1;
      end
      tick();
      if (i == 5) begin
        stats_clr = 1'b0;
        chk("clr_samples", int'(sample_count), 0);
        chk("clr_ones", int'(ones_count), 0);
      end
    end
    idle(5);
    // samples emerging after the clear edge: those accepted at i=3..9
    chk("clr_after_samples", int'(sample_count), 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
